// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: state encoding,
// time-field widths and the power-on alarm time (12:00 AM).
package alarm_pkg;

  localparam int HOUR_W = 4;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } alarm_state_e;

  localparam logic [HOUR_W-1:0] RST_ALARM_HOUR = 4'd12;
  localparam logic [MIN_W-1:0]  RST_ALARM_MIN  = 6'd0;
  localparam logic              RST_ALARM_PM   = 1'b0;

endpackage

// File: rtl/alarm_unit_if.sv
// Bundle of live timer time, alarm programming, user controls and alarm
// outputs; the alarm controller is the slave, the timer/user side the master.
interface alarm_unit_if;

  logic [alarm_pkg::HOUR_W-1:0] hourNow;
  logic [alarm_pkg::MIN_W-1:0]  minNow;
  logic [alarm_pkg::SEC_W-1:0]  secNow;
  logic                         pmNow;
  logic                         alarmSet;
  logic [alarm_pkg::HOUR_W-1:0] alarmHour;
  logic [alarm_pkg::MIN_W-1:0]  alarmMin;
  logic                         alarmPm;
  logic                         enable;
  logic                         snooze;
  logic                         stop;
  logic                         ring;
  logic                         chime;
  logic [1:0]                   alarmState;

  modport slave (
    input  hourNow, minNow, secNow, pmNow,
    input  alarmSet, alarmHour, alarmMin, alarmPm,
    input  enable, snooze, stop,
    output ring, chime, alarmState
  );

  modport master (
    output hourNow, minNow, secNow, pmNow,
    output alarmSet, alarmHour, alarmMin, alarmPm,
    output enable, snooze, stop,
    input  ring, chime, alarmState
  );

endinterface

// File: rtl/alarm_unit_sec_tick_detect.sv
// Second-tick detector: a tick is any clock on which the timer's seconds
// field differs from the value seen on the previous clock.
module sec_tick_detect
  import alarm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SEC_W-1:0] sec,
  output logic             tick
);

  logic [SEC_W-1:0] sec_prev;

  always_ff @(posedge clk) begin
    if (!reset) sec_prev <= '0;
    else        sec_prev <= sec;
  end

  assign tick = (sec != sec_prev);

endmodule

// File: rtl/alarm_unit.sv
// Alarm controller downstream of the timer: arms, rings, snoozes and
// auto-silences. Define ALARM_HOURLY_CHIME_EN to enable the top-of-hour chime.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic         clk,
  input  logic         reset,
  alarm_unit_if.slave  bus
);

  localparam int RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam int SNZ_W  = $clog2(SNOOZE_MIN * 60 + 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_MIN * 60);

  alarm_state_e      state;
  logic [HOUR_W-1:0] alarm_hour;
  logic [MIN_W-1:0]  alarm_min;
  logic              alarm_pm;
  logic [RING_W-1:0] ring_cnt;
  logic [SNZ_W-1:0]  snz_cnt;
  logic              tick;
  logic              match;

  sec_tick_detect u_tick (
    .clk   (clk),
    .reset (reset),
    .sec   (bus.secNow),
    .tick  (tick)
  );

  // Only the exact hh:mm:00 instant triggers; a timer loaded later in the minute does not.
  assign match = bus.enable && (bus.hourNow == alarm_hour) && (bus.minNow == alarm_min)
              && (bus.secNow == '0) && (bus.pmNow == alarm_pm);

  assign bus.alarmState = state;

  // NOTE: every register here updates with <=, so match below still sees the
  // old alarm registers on a cycle where alarmSet loads new ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= DISARMED;
      bus.ring   <= 1'b0;
      alarm_hour <= RST_ALARM_HOUR;
      alarm_min  <= RST_ALARM_MIN;
      alarm_pm   <= RST_ALARM_PM;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
    end else begin
      if (bus.alarmSet) begin
        alarm_hour <= bus.alarmHour;
        alarm_min  <= bus.alarmMin;
        alarm_pm   <= bus.alarmPm;
      end

      if (!bus.enable) begin
        state    <= DISARMED;
        bus.ring <= 1'b0;
        ring_cnt <= '0;
        snz_cnt  <= '0;
      end else if (bus.alarmSet && (state == RINGING || state == SNOOZE)) begin
        state    <= ARMED;
        bus.ring <= 1'b0;
      end else begin
        case (state)
          DISARMED: begin
            state    <= ARMED;
            bus.ring <= 1'b0;
          end
          ARMED: begin
            if (match) begin
              state    <= RINGING;
              ring_cnt <= '0;
              bus.ring <= 1'b1;
            end else begin
              bus.ring <= 1'b0;
            end
          end
          RINGING: begin
            if (bus.stop) begin
              state    <= ARMED;
              bus.ring <= 1'b0;
            end else if (bus.snooze) begin
              state    <= SNOOZE;
              snz_cnt  <= SNZ_LOAD;
              bus.ring <= 1'b0;
            end else if (tick && ring_cnt == RING_LAST) begin
              state    <= ARMED;
              bus.ring <= 1'b0;
            end else begin
              if (tick) ring_cnt <= ring_cnt + RING_W'(1);
              bus.ring <= 1'b1;
            end
          end
          SNOOZE: begin
            if (bus.stop) begin
              state    <= ARMED;
              bus.ring <= 1'b0;
            end else if (tick && snz_cnt == SNZ_W'(1)) begin
              state    <= RINGING;
              ring_cnt <= '0;
              bus.ring <= 1'b1;
            end else begin
              if (tick && snz_cnt != '0) snz_cnt <= snz_cnt - SNZ_W'(1);
              bus.ring <= 1'b0;
            end
          end
          default: begin
            state    <= DISARMED;
            bus.ring <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ALARM_HOURLY_CHIME_EN
  // Chime ignores enable and alarm state; it follows the timer alone.
  always_ff @(posedge clk) begin
    if (!reset) bus.chime <= 1'b0;
    else        bus.chime <= tick && (bus.minNow == '0) && (bus.secNow == '0);
  end
`else
  assign bus.chime = 1'b0;
`endif

endmodule

// File: doc/alarm_unit.md
# alarm_unit

Alarm controller that sits directly downstream of `timer`. It consumes the live 12-hour time (hour, minute, second, AM/PM) and holds a programmed alarm time. A four-state machine arms, rings, snoozes and auto-silences the alarm. Second ticks are derived from changes in the timer's seconds field, so all durations are counted in timer seconds rather than raw clocks.

## Interface
Parameters:
- `SNOOZE_MIN`, default 5: snooze length in minutes, range 1..60.
- `RING_SEC`, default 60: auto-silence timeout in seconds, range 1..127.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `hourNow` in 4: timer hour, 1..12.
- `minNow` in 6: timer minute, 0..59.
- `secNow` in 6: timer second, 0..59.
- `pmNow` in 1: timer meridiem, 0 = AM, 1 = PM.
- `alarmSet` in 1: load the `alarmHour`/`alarmMin`/`alarmPm` inputs into the alarm registers.
- `alarmHour` in 4: alarm hour to load.
- `alarmMin` in 6: alarm minute to load.
- `alarmPm` in 1: alarm meridiem to load.
- `enable` in 1: level; 1 = alarm armed, 0 = disarmed.
- `snooze` in 1: snooze request, level-sampled each clock.
- `stop` in 1: silence request, level-sampled each clock.
- `ring` out 1: alarm sounding.
- `chime` out 1: one-cycle top-of-hour pulse.
- `alarmState` out 2: current state, encoded DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3.

## Operation
- Reset (`reset`=0 at a clock edge):
  - State = DISARMED; `ring`=0, `chime`=0.
  - Alarm registers = 12:00 AM.
  - `secPrev`=0; ring and snooze counters = 0.
- tick = (`secNow` != `secPrev`). `secPrev` takes `secNow` every clock.
- match = `enable` & (`hourNow`==alarmHour) & (`minNow`==alarmMin) & (`secNow`==0) & (`pmNow`==alarmPm).
  - Only the hh:mm:00 instant triggers. Loading the timer past :00 of the alarm minute does not ring.
- State transitions, highest priority first within each state:
  - `enable`=0 from any state -> DISARMED. Counters clear, `ring`=0.
  - DISARMED: `enable`=1 -> ARMED.
  - ARMED: match -> RINGING, ring counter cleared.
  - RINGING: `stop` -> ARMED. Otherwise `snooze` -> SNOOZE, snooze counter = SNOOZE_MIN*60. Otherwise, a tick with ring counter == RING_SEC-1 -> ARMED. Otherwise, a tick increments the ring counter.
  - SNOOZE: `stop` -> ARMED. Otherwise, a tick with snooze counter == 1 -> RINGING, ring counter cleared. Otherwise, a tick decrements the snooze counter.
- `alarmSet`:
  - Loads the alarm registers in any state, including during reset-free DISARMED.
  - In RINGING or SNOOZE it also forces ARMED.
  - `alarmSet` together with a match in the same cycle: match uses the old registers; the new value is visible next cycle.
- `ring` = registered (next state == RINGING).
- match is ignored in RINGING and SNOOZE; there is no re-trigger while already active.
- Counter widths: ring counter $clog2(RING_SEC); snooze counter $clog2(SNOOZE_MIN*60+1). The snooze counter never wraps.

## Timing
- One clock after `timeNow` shows the alarm hh:mm:00, `ring`=1 and `alarmState`=2.
- `stop`/`snooze` sampled at edge N: `ring`=0 after edge N.
- Ringing lasts exactly RING_SEC ticks. With a one-second-per-clock timer, that is RING_SEC cycles.
- Re-ring occurs on the SNOOZE_MIN*60-th tick after entering SNOOZE.
- Reset mid-RINGING: `ring`=0 at that edge, and all state is lost.

## Configuration
- `ALARM_HOURLY_CHIME_EN` defined:
  - `chime`=1 for one cycle when tick & `minNow`==0 & `secNow`==0.
  - Independent of `enable` and of the alarm state.
- `ALARM_HOURLY_CHIME_EN` undefined: the `chime` port exists and is tied to 0.

## Structure
- Package `alarm_pkg` holds:
  - State enum and its 2-bit encodings.
  - Reset alarm constants (hour 12, min 0, AM).
  - Widths HOUR_W=4, MIN_W=6, SEC_W=6.
- Sub-module `sec_tick_detect`: holds the `secPrev` register and produces `tick`.
- FSM, counters and compare logic live in `alarm_unit`.

## Test plan
- Reset: drive `reset`=0 for one edge -> `alarmState`=0, `ring`=0, alarm registers 12:00 AM.
- Alarm trigger: set alarm 7:00 AM, `enable`=1, timer 6:59:58 -> 6:59:59 -> 7:00:00 AM -> `ring` rises the clock after 7:00:00 and `alarmState`=2. The same sequence at 7:00:00 PM -> no ring.
- Auto-silence: RING_SEC=60, no inputs after ringing starts -> `ring` falls after 60 ticks, `alarmState`=1.
- Snooze: SNOOZE_MIN=5, `snooze` at the 10th ring second -> `alarmState`=3, `ring`=0; after 300 ticks -> `ring`=1 again.
- Priority: `stop` and `snooze` in the same cycle while RINGING -> ARMED. `enable`=0 during SNOOZE -> DISARMED, and no re-ring at the end of the snooze interval.
- Chime: timer 2:59:59 -> 3:00:00 with the macro defined -> exactly one-cycle `chime`. Without the macro, `chime` stays 0.
